// File: rtl/hex_display_ctrl_pkg.sv
// +----------------------------------------------------------------------+
// | hex_disp_pkg : shared states, modes and segment encodings            |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package hex_disp_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    UPDATE  = 2'd2
  } state_t;

  localparam logic MODE_HEX = 1'b0;
  localparam logic MODE_DEC = 1'b1;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  // Active-low patterns, bit0 = segment a .. bit6 = segment g
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

`default_nettype wire

// File: rtl/hex_display_ctrl_seg_encode.sv
// +----------------------------------------------------------------------+
// | hex_seg_encode : one hex digit plus blank flag -> active-low segments|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module hex_seg_encode
  import hex_disp_pkg::*;
(
  input  logic [3:0] digit_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);

  assign seg_o = blank_i ? SEG_BLANK : SEG_TABLE[digit_i];

endmodule

`default_nettype wire

// File: rtl/hex_display_ctrl.sv
// +----------------------------------------------------------------------+
// | hex_display_ctrl : multi-digit 7-seg controller, hex or decimal view |
// | Optional flashing via macro HEX_DISP_BLINK_EN.          Rev 1.0      |
// +----------------------------------------------------------------------+
`default_nettype none

module hex_display_ctrl
  import hex_disp_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int DATA_W     = 32,
  parameter int BLINK_DIV  = 25000000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DATA_W-1:0]       value,
  input  logic                    load,
  input  logic                    mode,
  input  logic                    blank_lz,
`ifdef HEX_DISP_BLINK_EN
  input  logic                    blink,
`endif
  output logic                    busy,
  output logic                    ovf,
  output logic [7*NUM_DIGITS-1:0] HEX
);

  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int CNT_W = $clog2(DATA_W + 1);

  if (NUM_DIGITS < 1 || NUM_DIGITS > 8 || DATA_W < 4 || DATA_W > 32 || BLINK_DIV < 1) begin : g_bad_cfg
    $error("hex_display_ctrl: unsupported parameter set");
  end

  state_t                  state_q;
  logic [DATA_W-1:0]       bin_q, bin_d;
  logic [BCD_W-1:0]        bcd_q, bcd_d, bcd_adj_d;
  logic                    carry_d;
  logic [CNT_W-1:0]        cnt_q;
  logic                    mode_q, blank_lz_q, sticky_q, busy_q, ovf_q;
  logic [7*NUM_DIGITS-1:0] hex_q, seg_d;
  logic [BCD_W-1:0]        hex_nib_d, disp_nib_d;
  logic [NUM_DIGITS-1:0]   lz_d, dig_blank_d;

  // One double-dabble step: correct nibbles >= 5, then shift BCD:binary left
  always_comb begin
    bcd_adj_d = bcd_q;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (bcd_q[4*k +: 4] >= 4'd5) bcd_adj_d[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
    end
    {carry_d, bcd_d, bin_d} = {bcd_adj_d, bin_q, 1'b0};
  end

  for (genvar b = 0; b < BCD_W; b++) begin : g_hex_bit
    if (b < DATA_W) begin : g_data
      assign hex_nib_d[b] = bin_q[b];
    end else begin : g_pad
      assign hex_nib_d[b] = 1'b0;
    end
  end

  assign disp_nib_d = (mode_q == MODE_DEC) ? bcd_q : hex_nib_d;

  // lz_d[k]: digit k and every digit above it are zero
  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
    logic upper_zero;
    if (k == NUM_DIGITS - 1) begin : g_top
      assign upper_zero = 1'b1;
    end else begin : g_mid
      assign upper_zero = lz_d[k+1];
    end
    assign lz_d[k]        = upper_zero && (disp_nib_d[4*k +: 4] == 4'd0);
    assign dig_blank_d[k] = blank_lz_q && (k != 0) && lz_d[k];

    hex_seg_encode u_enc (
      .digit_i (disp_nib_d[4*k +: 4]),
      .blank_i (dig_blank_d[k]),
      .seg_o   (seg_d[7*k +: 7])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      bin_q      <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      mode_q     <= MODE_HEX;
      blank_lz_q <= 1'b0;
      sticky_q   <= 1'b0;
      busy_q     <= 1'b0;
      ovf_q      <= 1'b0;
      hex_q      <= {NUM_DIGITS{SEG_BLANK}};
    end else begin
      case (state_q)
        IDLE: begin
          if (load) begin
            bin_q      <= value;
            mode_q     <= mode;
            blank_lz_q <= blank_lz;
            bcd_q      <= '0;
            cnt_q      <= '0;
            sticky_q   <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= (mode == MODE_DEC) ? CONVERT : UPDATE;
          end
        end
        CONVERT: begin
          bin_q    <= bin_d;
          bcd_q    <= bcd_d;
          sticky_q <= sticky_q | carry_d;
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(DATA_W - 1)) state_q <= UPDATE;
        end
        UPDATE: begin
          ovf_q   <= (mode_q == MODE_DEC) && sticky_q;
          hex_q   <= ((mode_q == MODE_DEC) && sticky_q) ? {NUM_DIGITS{SEG_DASH}} : seg_d;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign ovf  = ovf_q;

`ifdef HEX_DISP_BLINK_EN
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [BLINK_W-1:0] blink_cnt_q;
  logic               blink_off_q;

  // Blanking only gates the output; stored digits are untouched
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt_q <= '0;
      blink_off_q <= 1'b0;
    end else if (!blink) begin
      blink_cnt_q <= '0;
      blink_off_q <= 1'b0;
    end else if (blink_cnt_q == BLINK_W'(BLINK_DIV - 1)) begin
      blink_cnt_q <= '0;
      blink_off_q <= ~blink_off_q;
    end else begin
      blink_cnt_q <= blink_cnt_q + 1'b1;
    end
  end

  assign HEX = (blink && blink_off_q) ? {NUM_DIGITS{SEG_BLANK}} : hex_q;
`else
  assign HEX = hex_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hex_display_ctrl.sv
// +----------------------------------------------------------------------+
// | tb_hex_display_ctrl : directed checks of hex_display_ctrl (8x32)     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_hex_display_ctrl;

  localparam logic [55:0] ALL_BLANK = {8{7'h7F}};
  localparam logic [55:0] ALL_DASH  = {8{7'h3F}};
  localparam logic [55:0] ALL_NINE  = {8{7'h10}};

  logic        clk;
  logic        rst_n;
  logic [31:0] value;
  logic        load;
  logic        mode;
  logic        blank_lz;
  logic        busy;
  logic        ovf;
  logic [55:0] HEX;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int cyc;
  logic [55:0] mid_hex;

  hex_display_ctrl #(
    .NUM_DIGITS (8),
    .DATA_W     (32),
    .BLINK_DIV  (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .value    (value),
    .load     (load),
    .mode     (mode),
    .blank_lz (blank_lz),
    .busy     (busy),
    .ovf      (ovf),
    .HEX      (HEX)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Pulse load for one cycle, then count cycles with busy high (bounded)
  task automatic load_and_wait(input logic [31:0] v, input logic m, input logic blz,
                               input bit noise, output int cycles, output logic [55:0] snap);
    @(negedge clk);
    value = v; mode = m; blank_lz = blz; load = 1'b1;
    @(negedge clk);
    load   = 1'b0;
    cycles = 0;
    snap   = HEX;
    while (busy && cycles < 200) begin
      cycles++;
      if (noise && cycles < 5) begin
        load = 1'b1; value = 32'h0000FFFF; mode = 1'b0; blank_lz = 1'b0;
      end else begin
        load = 1'b0;
      end
      if (cycles == 10) snap = HEX;
      @(negedge clk);
    end
    load = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; load = 1'b0; value = '0; mode = 1'b0; blank_lz = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_hex",  64'(HEX),  64'(ALL_BLANK));
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_ovf",  64'(ovf),  64'd0);
    rst_n = 1'b1;

    load_and_wait(32'h1234ABCD, 1'b0, 1'b0, 1'b0, cyc, mid_hex);
    check("hex_busy_cycles", 64'(cyc), 64'd1);
    check("hex_1234abcd", 64'(HEX),
          64'({7'h79, 7'h24, 7'h30, 7'h19, 7'h08, 7'h03, 7'h46, 7'h21}));
    check("hex_ovf", 64'(ovf), 64'd0);

    load_and_wait(32'd12345, 1'b1, 1'b1, 1'b0, cyc, mid_hex);
    check("dec_busy_cycles", 64'(cyc), 64'd33);
    check("dec_12345", 64'(HEX),
          64'({7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12}));
    check("dec_12345_ovf", 64'(ovf), 64'd0);

    load_and_wait(32'd0, 1'b1, 1'b1, 1'b0, cyc, mid_hex);
    check("dec_zero_blank", 64'(HEX), 64'({{7{7'h7F}}, 7'h40}));

    load_and_wait(32'h000000A0, 1'b0, 1'b1, 1'b0, cyc, mid_hex);
    check("hex_a0_blank", 64'(HEX), 64'({{6{7'h7F}}, 7'h08, 7'h40}));

    load_and_wait(32'd42, 1'b1, 1'b1, 1'b1, cyc, mid_hex);
    check("noise_busy_cycles", 64'(cyc), 64'd33);
    check("noise_hold_during_convert", 64'(mid_hex), 64'({{6{7'h7F}}, 7'h08, 7'h40}));
    check("noise_dec_42", 64'(HEX), 64'({{6{7'h7F}}, 7'h19, 7'h24}));

    load_and_wait(32'd100000000, 1'b1, 1'b0, 1'b0, cyc, mid_hex);
    check("ovf_dash", 64'(HEX), 64'(ALL_DASH));
    check("ovf_flag", 64'(ovf),  64'd1);

    // Reset in the middle of a conversion
    @(negedge clk);
    value = 32'd99999999; mode = 1'b1; blank_lz = 1'b0; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (9) @(negedge clk);
    check("busy_before_reset", 64'(busy), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_hex",  64'(HEX),  64'(ALL_BLANK));
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_ovf",  64'(ovf),  64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    load_and_wait(32'd5, 1'b0, 1'b0, 1'b0, cyc, mid_hex);
    check("post_rst_busy_cycles", 64'(cyc), 64'd1);
    check("post_rst_hex5", 64'(HEX), 64'({{7{7'h40}}, 7'h12}));

    load_and_wait(32'd99999999, 1'b1, 1'b0, 1'b0, cyc, mid_hex);
    check("dec_max_nines", 64'(HEX), 64'(ALL_NINE));
    check("dec_max_ovf",   64'(ovf), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/hex_display_ctrl.md
Name: hex_display_ctrl

Overview:
Parametrised multi-digit seven-segment display controller; successor to the single-digit combinational hex decoder.
- Captures a binary value on a load strobe.
- Shows it in hex or decimal across NUM_DIGITS active-low digits, with optional leading-zero blanking and overflow indication.
- Decimal mode uses a sequential shift-add-3 (double-dabble) converter.
- Sits between CPU-visible registers and the board HEX outputs in the top level.

Parameters:
NUM_DIGITS, 8, number of seven-segment digits driven (1..8)
DATA_W, 32, width of the input value in bits (4..32)
BLINK_DIV, 25000000, clk cycles per blink half-period (used only with HEX_DISP_BLINK_EN)

Ports:
clk  input  1  system clock; all state changes on rising edge
rst_n  input  1  asynchronous active-low reset
value  input  DATA_W  binary value to display; sampled only on an accepted load
load  input  1  load strobe; accepted only when busy=0
mode  input  1  0 = hex display, 1 = decimal display; sampled with value
blank_lz  input  1  1 = blank leading zero digits; sampled with value
busy  output  1  high while a load is being processed; loads ignored while high
ovf  output  1  high while the displayed decimal value overflowed NUM_DIGITS digits
HEX  output  7*NUM_DIGITS  segments; digit k occupies bits [7k+6:7k]; bit0=a..bit6=g; active-low
blink  input  1  (present only with HEX_DISP_BLINK_EN) 1 = flash display

Behaviour:
- Reset (async assert, sync release): state IDLE; busy=0; ovf=0; every HEX digit 7'h7F (blank); internal capture, BCD and shift registers cleared.
- FSM states:
  - IDLE: load=1 -> capture value/mode/blank_lz. Go to CONVERT if mode=1, else UPDATE.
  - CONVERT: runs exactly DATA_W cycles. Each cycle, add 3 to every BCD nibble >=5, then shift the BCD:binary register left by 1. A 1 shifted out of the top BCD nibble sets a sticky overflow bit. After the last shift -> UPDATE.
  - UPDATE: one cycle; registers all digit encodings and ovf -> IDLE.
- busy is a registered output: high in CONVERT and UPDATE, low in IDLE.
- Latency from the load cycle t to new HEX visible:
  - Hex mode: t+2.
  - Decimal mode: t+DATA_W+2.
- HEX holds its value between updates.
- Hex mode digit k = value nibble k. Nibbles beyond DATA_W are zero. Nibbles above NUM_DIGITS are ignored and never flag overflow; ovf=0.
- Decimal overflow (value >= 10^NUM_DIGITS): all digits show dash 7'h3F; ovf=1 until the next UPDATE.
- Leading-zero blanking: digits above the most-significant nonzero digit show 7'h7F. Digit 0 is never blanked, so value 0 shows "0".
- Encodings (hex, active-low):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
- load while busy=1: ignored, with no effect on the conversion or the captured data.
- load held high: re-accepted on each IDLE cycle.
- rst_n asserted mid-conversion: immediate return to reset values; no partial result is ever shown.

Optional Feature:
Macro HEX_DISP_BLINK_EN.
- Defined: adds the blink port and a counter that wraps at BLINK_DIV-1. While blink=1, HEX is forced to 7'h7F during alternate half-periods, without altering stored digits. Counter reset value 0; display visible in the first half-period. blink=0 clears the counter and shows digits steadily.
- Undefined: no blink port or counter; BLINK_DIV unused.

Decomposition:
- Package hex_disp_pkg:
  - State enum (IDLE, CONVERT, UPDATE).
  - Mode constants MODE_HEX/MODE_DEC.
  - Segment constants SEG_BLANK=7'h7F, SEG_DASH=7'h3F.
  - 16-entry hex-to-segment constant table.
- Sub-module hex_seg_encode: combinational 4-bit digit plus blank flag -> 7-bit active-low segments. One instance per digit, via generate.

Test Plan:
- Reset, then hex load of 32'h1234ABCD, blank_lz=0 -> busy for 1 cycle; at t+2, HEX digits 7..0 = 79,24,30,19,08,03,46,21; ovf=0.
- Decimal load of 12345, blank_lz=1 -> busy for 33 cycles; then digits 7..5 = 7F, digits 4..0 = 79,24,30,19,12.
- Decimal load of 0 with blank_lz=1 -> digit 0 = 40; digits 7..1 = 7F.
- Decimal load of 100000000 (NUM_DIGITS=8) -> all digits 3F; ovf=1. A following decimal load of 99999999 -> all digits 10; ovf=0.
- Loads pulsed during CONVERT with different values -> ignored; first value displayed; latency unchanged.
- rst_n pulsed low at CONVERT cycle 10 -> HEX all 7F, busy=0 asynchronously. Fresh hex load of 5 afterwards -> digit 0 = 12 at t+2.
